// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle main control FSM for the 16-bit CPU
// Optional feature: define MC_JUMP_EN to decode opcode 0111 as a jump.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [1:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_fault
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REX     = 4'd6,
    S_IEX     = 4'd7,
    S_ALUWB_R = 4'd8,
    S_ALUWB_I = 4'd9,
    S_BRANCH  = 4'd10,
`ifdef MC_JUMP_EN
    S_JUMP    = 4'd11,
`endif
    S_FAULT   = 4'd15
  } state_t;

  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     cur;
  state_t     nxt;
  logic [3:0] wait_cnt;
  logic       fault_q;
  logic       store_q;
  logic       in_mem;
  logic       timeout;
  logic       op_illegal;
  logic       unused_funct;

  assign unused_funct = ^funct;
  assign state        = cur;
  assign mem_fault    = fault_q;
  assign in_mem       = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
  assign timeout      = (wait_cnt == TIMEOUT_LAST);

  // The wait counter restarts whenever the state changes, so each memory state gets a fresh budget.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= S_FETCH;
      wait_cnt <= 4'd0;
      fault_q  <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt != cur)
        wait_cnt <= 4'd0;
      else if (in_mem && !mem_ready)
        wait_cnt <= wait_cnt + 4'd1;
      if (nxt == S_FAULT)
        fault_q <= 1'b1;
      if (cur == S_DECODE)
        store_q <= (opcode == 4'b0101);
    end
  end

  always_comb begin
    nxt        = S_FETCH;
    op_illegal = 1'b0;
    case (cur)
      S_FETCH: begin
        if (mem_ready)    nxt = S_DECODE;
        else if (timeout) nxt = S_FAULT;
        else              nxt = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          4'b0000, 4'b0001:         nxt = S_REX;
          4'b0010, 4'b1001,
          4'b1010, 4'b1011:         nxt = S_IEX;
          4'b0100, 4'b0101:         nxt = S_MEMADR;
          4'b0110:                  nxt = S_BRANCH;
`ifdef MC_JUMP_EN
          4'b0111:                  nxt = S_JUMP;
`endif
          default: begin
            nxt        = S_FETCH;
            op_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: nxt = store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)    nxt = S_MEMWB;
        else if (timeout) nxt = S_FAULT;
        else              nxt = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready)    nxt = S_FETCH;
        else if (timeout) nxt = S_FAULT;
        else              nxt = S_MEMWR;
      end
      S_REX:   nxt = S_ALUWB_R;
      S_IEX:   nxt = S_ALUWB_I;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_FETCH;
    endcase
  end

  // Strobes are forced low in the reset cycle so an aborted access never writes.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = op_illegal;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        S_ALUWB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_ALUWB_I: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
`ifdef MC_JUMP_EN
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed-vector bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic [1:0] funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_fault;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    opcode    = 4'b0001;
    funct     = 2'b10;
    mem_ready = 1'b1;
    tick();
    tick();
    chk("rst_state", state, 4'd0);
    chk("rst_mem_read", {3'b0, mem_read}, 4'd0);
    chk("rst_ir_write", {3'b0, ir_write}, 4'd0);
    chk("rst_fault", {3'b0, mem_fault}, 4'd0);
    reset = 1'b0;
    #1;

    // ADD: 0,1,6,8,0
    chk("add_c1_state", state, 4'd0);
    chk("add_c1_mem_read", {3'b0, mem_read}, 4'd1);
    chk("add_c1_ir_write", {3'b0, ir_write}, 4'd1);
    chk("add_c1_pc_write", {3'b0, pc_write}, 4'd1);
    chk("add_c1_srcb", {2'b0, alu_src_b}, 4'd1);
    tick();
    chk("add_c2_state", state, 4'd1);
    chk("add_c2_srcb", {2'b0, alu_src_b}, 4'd3);
    chk("add_c2_reg_write", {3'b0, reg_write}, 4'd0);
    tick();
    chk("add_c3_state", state, 4'd6);
    chk("add_c3_alu_op", {2'b0, alu_op}, 4'd2);
    chk("add_c3_src_a", {3'b0, alu_src_a}, 4'd1);
    chk("add_c3_reg_write", {3'b0, reg_write}, 4'd0);
    tick();
    chk("add_c4_state", state, 4'd8);
    chk("add_c4_reg_write", {3'b0, reg_write}, 4'd1);
    chk("add_c4_reg_dst", {3'b0, reg_dst}, 4'd1);
    tick();
    chk("add_c5_state", state, 4'd0);
    chk("add_c5_reg_write", {3'b0, reg_write}, 4'd0);

    // LW with 3 wait cycles in MEMRD
    opcode = 4'b0100;
    tick();
    chk("lw_decode", state, 4'd1);
    tick();
    chk("lw_memadr", state, 4'd2);
    chk("lw_memadr_srcb", {2'b0, alu_src_b}, 4'd2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_memrd_wait_state", state, 4'd3);
      chk("lw_memrd_wait_read", {3'b0, mem_read}, 4'd1);
      chk("lw_memrd_wait_iord", {3'b0, i_or_d}, 4'd1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_memrd_last_state", state, 4'd3);
    chk("lw_memrd_last_read", {3'b0, mem_read}, 4'd1);
    tick();
    chk("lw_memwb_state", state, 4'd4);
    chk("lw_memwb_reg_write", {3'b0, reg_write}, 4'd1);
    chk("lw_memwb_mem_to_reg", {3'b0, mem_to_reg}, 4'd1);
    chk("lw_memwb_reg_dst", {3'b0, reg_dst}, 4'd0);
    tick();
    chk("lw_end_state", state, 4'd0);
    chk("lw_end_reg_write", {3'b0, reg_write}, 4'd0);

    // SW zero-wait: 0,1,2,5,0
    opcode = 4'b0101;
    tick();
    tick();
    chk("sw_memadr", state, 4'd2);
    tick();
    chk("sw_memwr_state", state, 4'd5);
    chk("sw_memwr_write", {3'b0, mem_write}, 4'd1);
    chk("sw_memwr_iord", {3'b0, i_or_d}, 4'd1);
    tick();
    chk("sw_end_state", state, 4'd0);
    chk("sw_end_write", {3'b0, mem_write}, 4'd0);

    // SLTI: I-format path 0,1,7,9,0
    opcode = 4'b1011;
    tick();
    tick();
    chk("slti_iex_state", state, 4'd7);
    chk("slti_iex_alu_op", {2'b0, alu_op}, 4'd3);
    chk("slti_iex_srcb", {2'b0, alu_src_b}, 4'd2);
    tick();
    chk("slti_wb_state", state, 4'd9);
    chk("slti_wb_reg_write", {3'b0, reg_write}, 4'd1);
    chk("slti_wb_reg_dst", {3'b0, reg_dst}, 4'd0);
    tick();

    // BEQ: 0,1,10,0
    opcode = 4'b0110;
    tick();
    tick();
    chk("beq_state", state, 4'd10);
    chk("beq_pwc", {3'b0, pc_write_cond}, 4'd1);
    chk("beq_alu_op", {2'b0, alu_op}, 4'd1);
    chk("beq_pc_source", {2'b0, pc_source}, 4'd1);
    tick();
    chk("beq_end_state", state, 4'd0);

    // Illegal opcode 1111: one-cycle pulse in DECODE
    opcode = 4'b1111;
    tick();
    chk("ill_decode_state", state, 4'd1);
    chk("ill_pulse", {3'b0, illegal_op}, 4'd1);
    chk("ill_reg_write", {3'b0, reg_write}, 4'd0);
    chk("ill_mem_write", {3'b0, mem_write}, 4'd0);
    tick();
    chk("ill_back_state", state, 4'd0);
    chk("ill_pulse_end", {3'b0, illegal_op}, 4'd0);

    // Opcode 0111: jump when compiled in, illegal otherwise
    opcode = 4'b0111;
    tick();
`ifdef MC_JUMP_EN
    chk("j_decode_ill", {3'b0, illegal_op}, 4'd0);
    tick();
    chk("j_state", state, 4'd11);
    chk("j_pc_write", {3'b0, pc_write}, 4'd1);
    chk("j_pc_source", {2'b0, pc_source}, 4'd2);
    tick();
    chk("j_end_state", state, 4'd0);
`else
    chk("j_ill_pulse", {3'b0, illegal_op}, 4'd1);
    tick();
    chk("j_ill_state", state, 4'd0);
`endif

    // FETCH timeout: 15 wait cycles then FAULT, sticky until reset
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      chk("to_fetch_state", state, 4'd0);
      chk("to_fetch_ir_write", {3'b0, ir_write}, 4'd0);
      chk("to_fetch_fault", {3'b0, mem_fault}, 4'd0);
      tick();
    end
    chk("to_fault_state", state, 4'd15);
    chk("to_fault_flag", {3'b0, mem_fault}, 4'd1);
    chk("to_fault_mem_read", {3'b0, mem_read}, 4'd0);
    mem_ready = 1'b1;
    tick();
    tick();
    chk("to_fault_hold_state", state, 4'd15);
    chk("to_fault_hold_flag", {3'b0, mem_fault}, 4'd1);
    reset = 1'b1;
    tick();
    chk("to_rst_state", state, 4'd0);
    chk("to_rst_flag", {3'b0, mem_fault}, 4'd0);
    chk("to_rst_mem_read", {3'b0, mem_read}, 4'd0);
    reset = 1'b0;
    #1;
    chk("to_after_rst_read", {3'b0, mem_read}, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
